// File: rtl/selthread_pkg.sv
// Shared constants and helpers for the N-thread issue selector.
package selthread_pkg;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  localparam int DEF_NTHREAD = 4;
  localparam int DEF_NSTAGE  = 4;

  // Thread-ID width; never narrower than one bit.
  function automatic int tid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/thread_rr_pick.sv
// Combinational picker: rotate the eligible mask by the pointer (or not,
// in fixed-priority mode), priority-encode, then un-rotate the index.
module thread_rr_pick
  import selthread_pkg::*;
#(
  parameter int NTHREAD = DEF_NTHREAD,
  parameter int TW      = tid_w(NTHREAD)
) (
  input  logic [NTHREAD-1:0] elig,
  input  logic [TW-1:0]      ptr,
  input  logic               prio_mode,
  output logic               found,
  output logic [TW-1:0]      id
);

  logic [TW-1:0]      sh;
  logic [NTHREAD-1:0] rot;
  logic [TW-1:0]      off;
  logic [TW:0]        sum;

  // Fixed priority is just round-robin with the rotation forced to zero.
  assign sh  = (prio_mode == PRIO_FIXED) ? '0 : ptr;
  assign rot = NTHREAD'({elig, elig} >> sh);

  // Lowest set bit of the rotated mask is the winner.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = NTHREAD - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = TW'(k);
      end
    end
  end

  // Undo the rotation modulo NTHREAD (handles non-power-of-2 counts).
  assign sum = {1'b0, sh} + {1'b0, off};
  assign id  = (sum >= (TW+1)'(NTHREAD)) ? TW'(sum - (TW+1)'(NTHREAD)) : TW'(sum);

endmodule

// File: rtl/selthread_n_threading.sv
// N-thread fine-grained issue selector with per-stage thread tag tracking
// and flush-driven kill of in-flight entries.
module selthread_n_threading
  import selthread_pkg::*;
#(
  parameter int NTHREAD = DEF_NTHREAD,
  parameter int TW      = tid_w(NTHREAD),
  parameter int NSTAGE  = DEF_NSTAGE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NTHREAD-1:0]   ready,
  input  logic [NTHREAD-1:0]   flush,
  input  logic                 prio_mode,
  output logic                 issue_v,
  output logic [TW-1:0]        dt,
  output logic [NTHREAD-1:0]   stall,
  output logic [TW-1:0]        ptr,
  output logic [NSTAGE-1:0]    stage_v,
  output logic [NSTAGE*TW-1:0] stage_t
);

  localparam int NP = 1 << TW;

  logic [NTHREAD-1:0]         elig;
  logic                       found;
  logic [TW-1:0]              pick_id;
  logic [NP-1:0]              fl_pad;
  logic [NSTAGE-1:0]          v_q, v_nxt;
  logic [NSTAGE-1:0][TW-1:0]  t_q, t_nxt;

  // A flushed thread is never eligible, so new entries never carry a dead tag.
  assign elig   = ready & ~flush;
  // Padded so any TW-bit tag indexes a real bit.
  assign fl_pad = NP'(flush);

  thread_rr_pick #(.NTHREAD(NTHREAD), .TW(TW)) u_pick (
    .elig      (elig),
    .ptr       (ptr),
    .prio_mode (prio_mode),
    .found     (found),
    .id        (pick_id)
  );

  assign issue_v = en & found;
  assign dt      = issue_v ? pick_id : '0;

  // Every ready thread that did not win this cycle stalls.
  always_comb begin
    stall = '0;
    for (int i = 0; i < NTHREAD; i++)
      stall[i] = ready[i] & ~(issue_v & (dt == TW'(i)));
  end

  // Shift or hold the tag pipe, then kill any entry whose thread is flushed.
  always_comb begin
    v_nxt = v_q;
    t_nxt = t_q;
    if (en) begin
      v_nxt[0] = issue_v;
      t_nxt[0] = dt;
      for (int k = 1; k < NSTAGE; k++) begin
        v_nxt[k] = v_q[k-1];
        t_nxt[k] = t_q[k-1];
      end
    end
    for (int k = 0; k < NSTAGE; k++)
      if (fl_pad[t_nxt[k]]) v_nxt[k] = 1'b0;
  end

  // Round-robin pointer: one past the last grant, in either mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (issue_v)
      ptr <= (dt == TW'(NTHREAD - 1)) ? '0 : dt + TW'(1);
  end

  // Stage valid/tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      t_q <= '0;
    end else begin
      v_q <= v_nxt;
      t_q <= t_nxt;
    end
  end

  assign stage_v = v_q;
  assign stage_t = t_q;

endmodule

// File: tb/tb_selthread_n_threading.sv
// Bench for selthread_n_threading: directed steps plus random traffic
// against a behavioural model of thread selection and the tag pipe.
module tb_selthread_n_threading;

  localparam int N  = 4;
  localparam int TW = 2;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [N-1:0]  ready = '0;
  logic [N-1:0]  flush = '0;
  logic          prio_mode = 1'b0;
  logic          issue_v;
  logic [TW-1:0] dt;
  logic [N-1:0]  stall;
  logic [TW-1:0] ptr;
  logic [NS-1:0] stage_v;
  logic [NS*TW-1:0] stage_t;

  // Second instance with a non-power-of-2 thread count.
  logic [2:0]    ready3 = '0;
  logic          issue_v3;
  logic [1:0]    dt3;
  logic [2:0]    stall3;
  logic [1:0]    ptr3;
  logic [3:0]    stage_v3;
  logic [7:0]    stage_t3;

  always #5 clk = ~clk;

  selthread_n_threading #(.NTHREAD(N), .NSTAGE(NS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ready(ready), .flush(flush),
    .prio_mode(prio_mode), .issue_v(issue_v), .dt(dt), .stall(stall),
    .ptr(ptr), .stage_v(stage_v), .stage_t(stage_t)
  );

  selthread_n_threading #(.NTHREAD(3), .NSTAGE(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .ready(ready3), .flush(3'b000),
    .prio_mode(1'b0), .issue_v(issue_v3), .dt(dt3), .stall(stall3),
    .ptr(ptr3), .stage_v(stage_v3), .stage_t(stage_t3)
  );

  int npass = 0;
  int nchk  = 0;

  // Behavioural model state
  int m_ptr;
  int m_v[NS];
  int m_t[NS];
  int e_iv, e_dt, e_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_ptr = 0;
    for (int k = 0; k < NS; k++) begin m_v[k] = 0; m_t[k] = 0; end
  endtask

  // Which thread wins, from the selection rules.
  task automatic m_comb();
    int el;
    el = ready & ~flush;
    e_iv = (en && el != 0) ? 1 : 0;
    e_dt = 0;
    if (e_iv != 0) begin
      for (int k = N - 1; k >= 0; k--) begin
        int j;
        j = prio_mode ? k : (m_ptr + k) % N;
        if (el[j]) e_dt = j;
      end
    end
    e_stall = 0;
    for (int i = 0; i < N; i++)
      if (ready[i] && !(e_iv != 0 && e_dt == i)) e_stall |= (1 << i);
  endtask

  task automatic m_clock();
    if (en) begin
      if (e_iv != 0) m_ptr = (e_dt + 1) % N;
      for (int k = NS - 1; k > 0; k--) begin m_v[k] = m_v[k-1]; m_t[k] = m_t[k-1]; end
      m_v[0] = e_iv; m_t[0] = e_dt;
    end
    for (int k = 0; k < NS; k++)
      if (m_v[k] != 0 && flush[m_t[k]]) m_v[k] = 0;
  endtask

  task automatic chk_regs(input string tag);
    int ev;
    ev = 0;
    for (int k = 0; k < NS; k++) if (m_v[k] != 0) ev |= (1 << k);
    chk({tag, ".ptr"}, 32'(ptr), 32'(m_ptr));
    chk({tag, ".stage_v"}, 32'(stage_v), 32'(ev));
    for (int k = 0; k < NS; k++)
      if (m_v[k] != 0) chk({tag, ".stage_t"}, 32'(stage_t[k*TW +: TW]), 32'(m_t[k]));
  endtask

  // One cycle: apply inputs, check selection, clock, check registers.
  task automatic cyc(input string tag, input logic e, input logic [N-1:0] r,
                     input logic [N-1:0] f, input logic p);
    en = e; ready = r; flush = f; prio_mode = p;
    #1;
    m_comb();
    chk({tag, ".issue_v"}, 32'(issue_v), 32'(e_iv));
    chk({tag, ".dt"}, 32'(dt), 32'(e_dt));
    chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
    @(posedge clk);
    m_clock();
    #1;
    chk_regs(tag);
  endtask

  initial begin
    m_reset();
    #2;
    chk("rst.ptr", 32'(ptr), 32'd0);
    chk("rst.stage_v", 32'(stage_v), 32'd0);
    chk("rst.stage_t", 32'(stage_t), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin over ready=1010
    cyc("rr0", 1'b1, 4'b1010, 4'b0000, 1'b0);
    chk("rr0.dt_lit", 32'(e_dt), 32'd1);
    cyc("rr1", 1'b1, 4'b1010, 4'b0000, 1'b0);
    // Fixed priority: thread 1 every time, pointer parks at 2
    for (int i = 0; i < 3; i++) cyc("fix", 1'b1, 4'b1010, 4'b0000, 1'b1);
    chk("fix.ptr_lit", 32'(ptr), 32'd2);

    // Drain, then single issue of thread 2 walking the pipe
    for (int i = 0; i < NS; i++) cyc("drain", 1'b1, 4'b0000, 4'b0000, 1'b0);
    cyc("tag0", 1'b1, 4'b0100, 4'b0000, 1'b0);
    for (int i = 0; i < NS + 1; i++) cyc("tagw", 1'b1, 4'b0000, 4'b0000, 1'b0);
    chk("tag.empty", 32'(stage_v), 32'd0);

    // Flush with en=1: thread 2 in stage 1, thread 1 in stage 0
    cyc("fl.a", 1'b1, 4'b0100, 4'b0000, 1'b1);
    cyc("fl.b", 1'b1, 4'b0010, 4'b0000, 1'b1);
    cyc("fl.en1", 1'b1, 4'b0000, 4'b0100, 1'b1);
    chk("fl.en1.v", 32'(stage_v), 32'b0010);
    // Flush with en=0: clears in place
    cyc("fl.c", 1'b1, 4'b0100, 4'b0000, 1'b1);
    cyc("fl.d", 1'b1, 4'b0010, 4'b0000, 1'b1);
    cyc("fl.en0", 1'b0, 4'b0000, 4'b0100, 1'b1);
    // en=0 stalls every ready thread
    cyc("hold", 1'b0, 4'b0111, 4'b0000, 1'b0);
    chk("hold.stall", 32'(stall), 32'b0111);
    cyc("flrdy", 1'b1, 4'b0110, 4'b0100, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r, f;
      r = 4'($urandom);
      f = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      cyc("rnd", ($urandom_range(0, 7) != 0), r, f, ($urandom_range(0, 3) == 0));
    end

    // Fill the pipe, then reset asynchronously mid-cycle
    for (int i = 0; i < NS; i++) cyc("fill", 1'b1, 4'b1111, 4'b0000, 1'b0);
    chk("fill.v", 32'(stage_v), 32'hf);
    ready = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.ptr", 32'(ptr), 32'd0);
    chk("arst.stage_v", 32'(stage_v), 32'd0);
    m_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc("idle", 1'b1, 4'b0000, 4'b0000, 1'b0);
    chk("idle.stall", 32'(stall), 32'd0);

    // NTHREAD=3 wrap: get ptr to 2, then issue thread 2
    en = 1'b1; ready = '0; ready3 = 3'b010;
    #1 chk("n3.dt1", 32'(dt3), 32'd1);
    @(posedge clk); #1;
    chk("n3.ptr2", 32'(ptr3), 32'd2);
    ready3 = 3'b100;
    #1 chk("n3.dt2", 32'(dt3), 32'd2);
    chk("n3.iv", 32'(issue_v3), 32'd1);
    @(posedge clk); #1;
    chk("n3.wrap", 32'(ptr3), 32'd0);
    ready3 = 3'b000;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
